// File: rtl/mine_resolve_if.sv
// Request/result bundle between cell-index logic, mine_resolve and the board/game-control blocks.
// Handshake: requests (flag/bomb) are single-cycle pulses sampled only while busy is low; there is no ready, so requests seen while busy are dropped.
interface mine_resolve_if #(
  parameter int MAX_SIZE = 16,
  parameter int IDX_W    = 4,
  parameter int CNT_W    = 9
);
  logic                       new_game;
  logic [1:0]                 level;
  logic [IDX_W-1:0]           button_ind_x_in;
  logic [IDX_W-1:0]           button_ind_y_in;
  logic                       flag;
  logic                       bomb;
  logic [MAX_SIZE*MAX_SIZE-1:0] mine_map;
  logic [CNT_W-1:0]           mine_total;
  logic                       busy;
  logic                       mark_flag;
  logic                       unmark_flag;
  logic                       explode;
  logic                       defuse;
  logic [3:0]                 neigh_cnt;
  logic [CNT_W-1:0]           flag_cnt;
  logic [CNT_W-1:0]           revealed_cnt;
  logic                       game_over;
  logic                       win;
  logic [2:0]                 state_dbg;

  modport master (
    output new_game, level, button_ind_x_in, button_ind_y_in, flag, bomb, mine_map, mine_total,
    input  busy, mark_flag, unmark_flag, explode, defuse, neigh_cnt, flag_cnt, revealed_cnt,
           game_over, win, state_dbg
  );

  modport slave (
    input  new_game, level, button_ind_x_in, button_ind_y_in, flag, bomb, mine_map, mine_total,
    output busy, mark_flag, unmark_flag, explode, defuse, neigh_cnt, flag_cnt, revealed_cnt,
           game_over, win, state_dbg
  );
endinterface

// File: rtl/mine_resolve.sv
// Per-cell flag/reveal resolver with win/game-over tracking for boards up to MAX_SIZE x MAX_SIZE.
// MINE_RESOLVE_NEIGH_EN builds the 8-neighbour mine-count scan; without it neigh_cnt is tied to 0.
module mine_resolve #(
  parameter int MAX_SIZE = 16,
  parameter int IDX_W    = 4,
  parameter int CNT_W    = 9
) (
  input logic           clk,
  input logic           rst,
  mine_resolve_if.slave bus
);
  localparam int CELLS  = MAX_SIZE * MAX_SIZE;
  localparam int CELL_W = $clog2(CELLS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, CHECK, SCAN, DONE, OVER} state_t;

  state_t           state;
  logic [IDX_W-1:0] cx, cy;
  logic             req_flag;
  logic [CELLS-1:0] flagged, revealed;
  logic [CNT_W-1:0] flag_q, rev_q;
  logic             mark_q, unmark_q, explode_q, defuse_q, over_q, win_q;

  logic [IDX_W:0]   size;
  logic             accept;
  logic [CELL_W-1:0] cur;
  logic [CNT_W-1:0] size_sq, target, rev_inc;

  always_comb begin
    case (bus.level)
      2'd1:    size = (IDX_W+1)'(8);
      2'd2:    size = (IDX_W+1)'(10);
      2'd3:    size = (IDX_W+1)'(MAX_SIZE);
      default: size = '0;
    endcase
  end

  assign accept  = (bus.flag | bus.bomb) && (bus.level != 2'd0) &&
                   ({1'b0, bus.button_ind_x_in} < size) && ({1'b0, bus.button_ind_y_in} < size);
  assign cur     = CELL_W'(cx) * CELL_W'(MAX_SIZE) + CELL_W'(cy);
  assign size_sq = CNT_W'(size) * CNT_W'(size);
  assign target  = size_sq - bus.mine_total;
  assign rev_inc = (rev_q == CNT_MAX) ? rev_q : rev_q + 1'b1;

`ifdef MINE_RESOLVE_NEIGH_EN
  localparam logic signed [IDX_W+1:0] NEG  = '1;
  localparam logic signed [IDX_W+1:0] ZERO = '0;
  localparam logic signed [IDX_W+1:0] ONE  = {{(IDX_W+1){1'b0}}, 1'b1};

  logic [2:0]               scan_idx;
  logic [3:0]               scan_cnt;
  logic [3:0]               neigh_q;
  logic signed [IDX_W+1:0]  dx, dy, nx, ny;
  logic                     n_in, n_hit;
  logic [CELL_W-1:0]        n_idx;

  // Fixed visiting order: row above, same row, row below (x is the row index).
  always_comb begin
    dx = ZERO;
    dy = ZERO;
    case (scan_idx)
      3'd0: begin dx = NEG;  dy = NEG;  end
      3'd1: begin dx = NEG;  dy = ZERO; end
      3'd2: begin dx = NEG;  dy = ONE;  end
      3'd3: begin dx = ZERO; dy = NEG;  end
      3'd4: begin dx = ZERO; dy = ONE;  end
      3'd5: begin dx = ONE;  dy = NEG;  end
      3'd6: begin dx = ONE;  dy = ZERO; end
      default: begin dx = ONE; dy = ONE; end
    endcase
    nx    = $signed({2'b00, cx}) + dx;
    ny    = $signed({2'b00, cy}) + dy;
    n_in  = (nx >= ZERO) && (nx < $signed({1'b0, size})) &&
            (ny >= ZERO) && (ny < $signed({1'b0, size}));
    n_idx = n_in ? CELL_W'(nx[IDX_W-1:0]) * CELL_W'(MAX_SIZE) + CELL_W'(ny[IDX_W-1:0]) : '0;
    n_hit = n_in && bus.mine_map[n_idx];
  end

  assign bus.neigh_cnt = neigh_q;
`else
  assign bus.neigh_cnt = 4'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cx        <= '0;
      cy        <= '0;
      req_flag  <= 1'b0;
      flagged   <= '0;
      revealed  <= '0;
      flag_q    <= '0;
      rev_q     <= '0;
      mark_q    <= 1'b0;
      unmark_q  <= 1'b0;
      explode_q <= 1'b0;
      defuse_q  <= 1'b0;
      over_q    <= 1'b0;
      win_q     <= 1'b0;
`ifdef MINE_RESOLVE_NEIGH_EN
      scan_idx  <= '0;
      scan_cnt  <= '0;
      neigh_q   <= '0;
`endif
    end else begin
      mark_q    <= 1'b0;
      unmark_q  <= 1'b0;
      explode_q <= 1'b0;
      defuse_q  <= 1'b0;
      if (bus.new_game) begin
        state    <= IDLE;
        flagged  <= '0;
        revealed <= '0;
        flag_q   <= '0;
        rev_q    <= '0;
        over_q   <= 1'b0;
        win_q    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              cx       <= bus.button_ind_x_in;
              cy       <= bus.button_ind_y_in;
              req_flag <= bus.flag;
              state    <= CHECK;
            end
          end
          CHECK: begin
            if (req_flag) begin
              if (revealed[cur]) begin
                state <= IDLE;
              end else if (flagged[cur]) begin
                flagged[cur] <= 1'b0;
                flag_q       <= (flag_q == '0) ? flag_q : flag_q - 1'b1;
                unmark_q     <= 1'b1;
                state        <= IDLE;
              end else begin
                flagged[cur] <= 1'b1;
                flag_q       <= (flag_q == CNT_MAX) ? flag_q : flag_q + 1'b1;
                mark_q       <= 1'b1;
                state        <= IDLE;
              end
            end else if (flagged[cur] || revealed[cur]) begin
              state <= IDLE;
            end else if (bus.mine_map[cur]) begin
              explode_q <= 1'b1;
              over_q    <= 1'b1;
              state     <= OVER;
            end else begin
`ifdef MINE_RESOLVE_NEIGH_EN
              scan_idx <= '0;
              scan_cnt <= '0;
              state    <= SCAN;
`else
              state    <= DONE;
`endif
            end
          end
          SCAN: begin
`ifdef MINE_RESOLVE_NEIGH_EN
            scan_cnt <= scan_cnt + {3'b000, n_hit};
            scan_idx <= scan_idx + 3'd1;
            if (scan_idx == 3'd7) state <= DONE;
`else
            state <= IDLE;
`endif
          end
          DONE: begin
            revealed[cur] <= 1'b1;
            rev_q         <= rev_inc;
            defuse_q      <= 1'b1;
`ifdef MINE_RESOLVE_NEIGH_EN
            neigh_q       <= scan_cnt;
`endif
            if (rev_inc == target) begin
              win_q <= 1'b1;
              state <= OVER;
            end else begin
              state <= IDLE;
            end
          end
          OVER:    state <= OVER;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.mark_flag    = mark_q;
  assign bus.unmark_flag  = unmark_q;
  assign bus.explode      = explode_q;
  assign bus.defuse       = defuse_q;
  assign bus.flag_cnt     = flag_q;
  assign bus.revealed_cnt = rev_q;
  assign bus.game_over    = over_q;
  assign bus.win          = win_q;
  assign bus.state_dbg    = state;
endmodule

// File: tb/tb_mine_resolve.sv
// Directed bench for mine_resolve: vector table for single requests plus win, new_game-abort and async-reset sequences.
module tb_mine_resolve;
  localparam int MAX_SIZE = 16;
  localparam int IDX_W    = 4;
  localparam int CNT_W    = 9;
  localparam int WIN_CYC  = 14;
`ifdef MINE_RESOLVE_NEIGH_EN
  localparam int LAT      = 11;
  localparam int N1       = 1;
  localparam int N3       = 3;
  localparam int ABORT_K  = 3;
`else
  localparam int LAT      = 3;
  localparam int N1       = 0;
  localparam int N3       = 0;
  localparam int ABORT_K  = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  mine_resolve_if #(.MAX_SIZE(MAX_SIZE), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  mine_resolve #(.MAX_SIZE(MAX_SIZE), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic f;
    logic b;
    int   x;
    int   y;
    int   mark_k;
    int   unmark_k;
    int   explode_k;
    int   defuse_k;
    int   busy_low_k;
    int   neigh;
    int   flag_cnt;
    int   rev_cnt;
    logic over;
    logic win;
  } vec_t;

  vec_t vecs [13];

  int n_checks = 0;
  int n_pass   = 0;
  int r_mark_k, r_unmark_k, r_explode_k, r_defuse_k;
  int r_mark_n, r_unmark_n, r_explode_n, r_defuse_n;
  int r_busy_low_k, r_busy_hi_n;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Drives one request pulse, then watches a fixed window of cycles (k = cycles after E0).
  task automatic do_req(input logic f, input logic b, input int x, input int y, input int abort_k);
    bus.flag            = f;
    bus.bomb            = b;
    bus.button_ind_x_in = 4'(x);
    bus.button_ind_y_in = 4'(y);
    r_mark_k = 0; r_unmark_k = 0; r_explode_k = 0; r_defuse_k = 0;
    r_mark_n = 0; r_unmark_n = 0; r_explode_n = 0; r_defuse_n = 0;
    r_busy_low_k = 0; r_busy_hi_n = 0;
    for (int k = 1; k <= WIN_CYC; k++) begin
      @(negedge clk);
      if (bus.mark_flag)   begin r_mark_n++;    if (r_mark_k == 0)    r_mark_k = k;    end
      if (bus.unmark_flag) begin r_unmark_n++;  if (r_unmark_k == 0)  r_unmark_k = k;  end
      if (bus.explode)     begin r_explode_n++; if (r_explode_k == 0) r_explode_k = k; end
      if (bus.defuse)      begin r_defuse_n++;  if (r_defuse_k == 0)  r_defuse_k = k;  end
      if (bus.busy) r_busy_hi_n++;
      else if (r_busy_low_k == 0) r_busy_low_k = k;
      if (k == 1) begin bus.flag = 1'b0; bus.bomb = 1'b0; end
      if (k == abort_k) bus.new_game = 1'b1;
      else if (k == abort_k + 1) bus.new_game = 1'b0;
    end
  endtask

  task automatic pulse_new_game();
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
  endtask

  task automatic check_vec(input int i);
    vec_t v;
    v = vecs[i];
    chk($sformatf("v%0d_mark_k", i),    r_mark_k,    v.mark_k);
    chk($sformatf("v%0d_unmark_k", i),  r_unmark_k,  v.unmark_k);
    chk($sformatf("v%0d_explode_k", i), r_explode_k, v.explode_k);
    chk($sformatf("v%0d_defuse_k", i),  r_defuse_k,  v.defuse_k);
    chk($sformatf("v%0d_mark_n", i),    r_mark_n,    (v.mark_k != 0) ? 1 : 0);
    chk($sformatf("v%0d_unmark_n", i),  r_unmark_n,  (v.unmark_k != 0) ? 1 : 0);
    chk($sformatf("v%0d_explode_n", i), r_explode_n, (v.explode_k != 0) ? 1 : 0);
    chk($sformatf("v%0d_defuse_n", i),  r_defuse_n,  (v.defuse_k != 0) ? 1 : 0);
    chk($sformatf("v%0d_busy_low_k", i), r_busy_low_k, v.busy_low_k);
    chk($sformatf("v%0d_neigh", i),     int'(bus.neigh_cnt),    v.neigh);
    chk($sformatf("v%0d_flag_cnt", i),  int'(bus.flag_cnt),     v.flag_cnt);
    chk($sformatf("v%0d_rev_cnt", i),   int'(bus.revealed_cnt), v.rev_cnt);
    chk($sformatf("v%0d_over", i),      int'(bus.game_over),    int'(v.over));
    chk($sformatf("v%0d_win", i),       int'(bus.win),          int'(v.win));
  endtask

  initial begin
    bus.new_game        = 1'b0;
    bus.level           = 2'd1;
    bus.button_ind_x_in = '0;
    bus.button_ind_y_in = '0;
    bus.flag            = 1'b0;
    bus.bomb            = 1'b0;
    bus.mine_map        = '0;
    bus.mine_map[3*MAX_SIZE+3] = 1'b1;
    bus.mine_total      = 9'd1;

    //            f     b     x  y  mk uk ek dk     bl   nb  fc rc ov    wn
    vecs[0]  = '{1'b0, 1'b1, 2, 2, 0, 0, 0, LAT, LAT, N1, 0, 1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 5, 5, 2, 0, 0, 0,   2,   N1, 1, 1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 5, 5, 0, 2, 0, 0,   2,   N1, 0, 1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 5, 5, 2, 0, 0, 0,   2,   N1, 1, 1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 5, 5, 0, 0, 0, 0,   2,   N1, 1, 1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 5, 5, 0, 2, 0, 0,   2,   N1, 0, 1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 7, 7, 0, 0, 0, LAT, LAT, 0,  0, 2, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2, 2, 0, 0, 0, 0,   2,   0,  0, 2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2, 2, 0, 0, 0, 0,   2,   0,  0, 2, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8, 0, 0, 0, 0, 0,   1,   0,  0, 2, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 4, 4, 0, 0, 0, LAT, LAT, N1, 0, 3, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 3, 3, 0, 0, 2, 0,   0,   N1, 0, 3, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 0, 0, 0, 0, 0, 0,   0,   N1, 0, 3, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",     int'(bus.busy), 0);
    chk("rst_pulses",   int'({bus.mark_flag, bus.unmark_flag, bus.explode, bus.defuse}), 0);
    chk("rst_neigh",    int'(bus.neigh_cnt), 0);
    chk("rst_flag_cnt", int'(bus.flag_cnt), 0);
    chk("rst_rev_cnt",  int'(bus.revealed_cnt), 0);
    chk("rst_over_win", int'({bus.game_over, bus.win}), 0);
    chk("rst_state",    int'(bus.state_dbg), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      do_req(vecs[i].f, vecs[i].b, vecs[i].x, vecs[i].y, 0);
      check_vec(i);
    end

    // new_game leaves OVER and clears everything
    pulse_new_game();
    chk("ng_busy",     int'(bus.busy), 0);
    chk("ng_over",     int'(bus.game_over), 0);
    chk("ng_rev_cnt",  int'(bus.revealed_cnt), 0);
    chk("ng_flag_cnt", int'(bus.flag_cnt), 0);

    // Win: only safe cell is the (0,0) corner
    bus.mine_map = '0;
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        if (x != 0 || y != 0) bus.mine_map[x*MAX_SIZE+y] = 1'b1;
    bus.mine_total = 9'd63;
    do_req(1'b0, 1'b1, 0, 0, 0);
    chk("win_defuse_k", r_defuse_k, LAT);
    chk("win_neigh",    int'(bus.neigh_cnt), N3);
    chk("win_rev_cnt",  int'(bus.revealed_cnt), 1);
    chk("win_win",      int'(bus.win), 1);
    chk("win_over",     int'(bus.game_over), 0);
    chk("win_busy",     int'(bus.busy), 1);
    do_req(1'b1, 1'b0, 1, 1, 0);
    chk("win_ignore_mark", r_mark_n, 0);
    pulse_new_game();
    chk("win_cleared", int'(bus.win), 0);

    // level 2: out-of-range x ignored, edge x=9 accepted; level 0 ignored
    bus.mine_map   = '0;
    bus.mine_total = 9'd0;
    bus.level      = 2'd2;
    do_req(1'b0, 1'b1, 12, 3, 0);
    chk("l2_x12_busy_hi", r_busy_hi_n, 0);
    chk("l2_x12_defuse",  r_defuse_n, 0);
    do_req(1'b0, 1'b1, 9, 9, 0);
    chk("l2_x9_defuse_k", r_defuse_k, LAT);
    chk("l2_x9_rev_cnt",  int'(bus.revealed_cnt), 1);
    bus.level = 2'd0;
    do_req(1'b1, 1'b0, 1, 1, 0);
    chk("l0_busy_hi", r_busy_hi_n, 0);
    chk("l0_mark",    r_mark_n, 0);

    // new_game mid-operation aborts with no pulse
    pulse_new_game();
    bus.level = 2'd1;
    bus.mine_map = '0;
    bus.mine_map[3*MAX_SIZE+3] = 1'b1;
    bus.mine_total = 9'd1;
    do_req(1'b1, 1'b0, 5, 5, 0);
    do_req(1'b0, 1'b1, 2, 2, 0);
    chk("ab_pre_flag", int'(bus.flag_cnt), 1);
    chk("ab_pre_rev",  int'(bus.revealed_cnt), 1);
    do_req(1'b0, 1'b1, 4, 4, ABORT_K);
    chk("ab_defuse_n",   r_defuse_n, 0);
    chk("ab_busy_low_k", r_busy_low_k, ABORT_K + 1);
    chk("ab_flag_cnt",   int'(bus.flag_cnt), 0);
    chk("ab_rev_cnt",    int'(bus.revealed_cnt), 0);
    do_req(1'b0, 1'b1, 2, 2, 0);
    chk("ab_rereveal_defuse_k", r_defuse_k, LAT);
    chk("ab_rereveal_rev",      int'(bus.revealed_cnt), 1);

    // Asynchronous rst in the middle of a reveal
    bus.bomb = 1'b1;
    bus.button_ind_x_in = 4'd4;
    bus.button_ind_y_in = 4'd4;
    @(negedge clk);
    bus.bomb = 1'b0;
    @(negedge clk);
    chk("ar_busy_before", int'(bus.busy), 1);
    #1 rst = 1'b1;
    #1;
    chk("ar_busy",    int'(bus.busy), 0);
    chk("ar_rev_cnt", int'(bus.revealed_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    r_defuse_n = 0;
    for (int k = 0; k < WIN_CYC; k++) begin
      @(negedge clk);
      if (bus.defuse) r_defuse_n++;
    end
    chk("ar_no_defuse", r_defuse_n, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
